// File: rtl/ir_cmd_scheduler.sv
// IR command scheduler: arbitrates bus/button requests into a pending command and
// launches one transmitter packet per slot, with a stop-watchdog and overrun flag.
module ir_cmd_scheduler #(
  parameter logic [7:0]  BASE_ADDR        = 8'h90,
  parameter int unsigned TICKS_PER_PACKET = 5_000_000,
  parameter int unsigned TIMEOUT_PACKETS  = 20
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  input  logic [7:0] BUS_DATA,
  input  logic       BTN_REQ,
  input  logic [3:0] BTN_CMD,
  input  logic       TX_BUSY,
  output logic       SEND_PACKET,
  output logic [3:0] COMMAND,
  output logic       SRC,
  output logic       TIMEOUT,
  output logic       OVERRUN
);

  localparam logic [22:0] SLOT_LAST = 23'(TICKS_PER_PACKET - 1);
  localparam logic [7:0]  WD_LIMIT  = (TIMEOUT_PACKETS > 255) ? 8'hFF : 8'(TIMEOUT_PACKETS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_ARM    = 2'd2,
    S_TX     = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [22:0] slot_q, slot_d;
  logic [7:0]  wd_q, wd_d;
  logic [3:0]  pend_q, pend_d;
  logic [3:0]  cmd_q, cmd_d;
  logic        src_q, src_d;
  logic        tmo_q, tmo_d;
  logic        ovr_q, ovr_d;

  logic        bus_req;
  logic        req_any;
  logic [3:0]  req_cmd;
  logic        tick;
  logic        launch;
  logic        unused_data;

  assign unused_data = ^BUS_DATA[7:4];

  // Bus has fixed priority; a losing button request is simply dropped.
  assign bus_req = BUS_WE && (BUS_ADDR == BASE_ADDR);
  assign req_any = bus_req || BTN_REQ;
  assign req_cmd = bus_req ? BUS_DATA[3:0] : BTN_CMD;
  assign tick    = (slot_q == SLOT_LAST);

  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tick) state_d = S_LAUNCH;
      end
      S_LAUNCH: begin
        if (!TX_BUSY) begin
          launch  = 1'b1;
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        state_d = S_TX;
      end
      S_TX: begin
        if (!TX_BUSY) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    slot_d = tick ? 23'd0 : slot_q + 23'd1;
    cmd_d  = launch ? pend_q : cmd_q;
    ovr_d  = ovr_q || (tick && (state_q != S_IDLE));

    wd_d = wd_q;
    if (req_any) begin
      wd_d = 8'd0;
    end else if (launch && (wd_q != 8'hFF)) begin
      wd_d = wd_q + 8'd1;
    end

    // A fresh request beats a watchdog expiry landing in the same cycle.
    pend_d = pend_q;
    src_d  = src_q;
    tmo_d  = tmo_q;
    if (req_any) begin
      pend_d = req_cmd;
      src_d  = !bus_req;
      tmo_d  = 1'b0;
    end else if (wd_q >= WD_LIMIT) begin
      pend_d = 4'b0000;
      tmo_d  = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      slot_q  <= 23'd0;
      wd_q    <= 8'd0;
      pend_q  <= 4'b0000;
      cmd_q   <= 4'b0000;
      src_q   <= 1'b0;
      tmo_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      wd_q    <= wd_d;
      pend_q  <= pend_d;
      cmd_q   <= cmd_d;
      src_q   <= src_d;
      tmo_q   <= tmo_d;
      ovr_q   <= ovr_d;
    end
  end

  // The launch cycle already presents the new command alongside the strobe.
  assign SEND_PACKET = launch;
  assign COMMAND     = launch ? pend_q : cmd_q;
  assign SRC         = src_q;
  assign TIMEOUT     = tmo_q;
  assign OVERRUN     = ovr_q;

endmodule

// File: tb/tb_ir_cmd_scheduler.sv
// Directed and randomized bench for ir_cmd_scheduler against a slot/packet reference model.
module tb_ir_cmd_scheduler;

  localparam int N  = 100;
  localparam int TO = 3;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] BUS_ADDR;
  logic       BUS_WE;
  logic [7:0] BUS_DATA;
  logic       BTN_REQ;
  logic [3:0] BTN_CMD;
  logic       TX_BUSY;
  logic       SEND_PACKET;
  logic [3:0] COMMAND;
  logic       SRC;
  logic       TIMEOUT;
  logic       OVERRUN;

  always #5 CLK = ~CLK;

  ir_cmd_scheduler #(
    .BASE_ADDR       (8'h90),
    .TICKS_PER_PACKET(N),
    .TIMEOUT_PACKETS (TO)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .BUS_ADDR   (BUS_ADDR),
    .BUS_WE     (BUS_WE),
    .BUS_DATA   (BUS_DATA),
    .BTN_REQ    (BTN_REQ),
    .BTN_CMD    (BTN_CMD),
    .TX_BUSY    (TX_BUSY),
    .SEND_PACKET(SEND_PACKET),
    .COMMAND    (COMMAND),
    .SRC        (SRC),
    .TIMEOUT    (TIMEOUT),
    .OVERRUN    (OVERRUN)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: cycles since reset, an owed slot, the arm cycle, draining packet.
  int         m_cyc;
  bit         m_owed, m_arm, m_drain;
  logic [3:0] m_pend, m_cmd;
  logic       m_src, m_tmo, m_ovr;
  int         m_wd;
  logic       m_send;
  logic [3:0] m_command;

  int         busy_left = 0;
  bit         force_busy = 0;
  int         cyc_no = 0;
  int         sends_seen = 0;
  int         last_send_cyc = -1;
  int         last_gap = -1;
  logic [3:0] last_cmd;
  logic       last_src;
  int         run_len = 0;
  int         max_run = 0;
  logic [3:0] cmd_log[$];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit tick, bus_ok, req, launch, idle;
    int wd_old;
    if (RST) begin
      m_cyc = 0; m_owed = 0; m_arm = 0; m_drain = 0;
      m_pend = 4'h0; m_cmd = 4'h0; m_src = 0; m_tmo = 0; m_ovr = 0; m_wd = 0;
      return;
    end
    bus_ok = BUS_WE && (BUS_ADDR == 8'h90);
    req    = bus_ok || BTN_REQ;
    tick   = (m_cyc % N) == N - 1;
    m_cyc++;
    idle   = !(m_owed || m_arm || m_drain);
    launch = m_owed && !TX_BUSY;
    if (tick && !idle) m_ovr = 1;
    if (launch) m_cmd = m_pend;
    wd_old = m_wd;
    if (idle) m_owed = tick;
    else if (m_owed) begin
      if (launch) begin m_owed = 0; m_arm = 1; end
    end else if (m_arm) begin
      m_arm = 0; m_drain = 1;
    end else if (!TX_BUSY) m_drain = 0;
    if (req) m_wd = 0;
    else if (launch && m_wd < 255) m_wd++;
    if (req) begin
      m_pend = bus_ok ? BUS_DATA[3:0] : BTN_CMD;
      m_src  = !bus_ok;
      m_tmo  = 0;
    end else if (wd_old >= TO) begin
      m_pend = 4'h0;
      m_tmo  = 1;
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    cyc_no++;
    #1;
    TX_BUSY = force_busy || (busy_left > 0);
    if (busy_left > 0) busy_left--;
    #1;
    m_send    = m_owed && !TX_BUSY;
    m_command = m_send ? m_pend : m_cmd;
    chk("send", SEND_PACKET, m_send);
    chk("command", COMMAND, m_command);
    chk("src", SRC, m_src);
    chk("timeout", TIMEOUT, m_tmo);
    chk("overrun", OVERRUN, m_ovr);
    chk("send_while_busy", SEND_PACKET && TX_BUSY, 1'b0);
    if (SEND_PACKET) begin
      sends_seen++;
      last_cmd = COMMAND;
      last_src = SRC;
      if (last_send_cyc >= 0) last_gap = cyc_no - last_send_cyc;
      last_send_cyc = cyc_no;
      cmd_log.push_back(COMMAND);
      busy_left = 10;
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wait_send(input int limit, output int k);
    k = 0;
    do begin
      step();
      k++;
    end while (!SEND_PACKET && k < limit);
    if (!SEND_PACKET) k = -1;
  endtask

  task automatic idle_inputs();
    BUS_WE = 0; BUS_ADDR = 8'h00; BUS_DATA = 8'h00; BTN_REQ = 0; BTN_CMD = 4'h0;
  endtask

  initial begin
    int k, base, qb, r;
    m_cyc = 0; m_owed = 0; m_arm = 0; m_drain = 0;
    m_pend = 0; m_cmd = 0; m_src = 0; m_tmo = 0; m_ovr = 0; m_wd = 0;
    TX_BUSY = 0;
    idle_inputs();
    RST = 1;
    run(3);
    chk("rst_send", SEND_PACKET, 1'b0);
    chk("rst_command", COMMAND, 4'h0);
    chk("rst_src", SRC, 1'b0);
    chk("rst_timeout", TIMEOUT, 1'b0);
    chk("rst_overrun", OVERRUN, 1'b0);
    RST = 0;
    last_send_cyc = -1;

    // Bus write at the register address, two packets 100 cycles apart
    BUS_WE = 1; BUS_ADDR = 8'h90; BUS_DATA = 8'h05;
    step();
    idle_inputs();
    run(210);
    chk("bus_cmd", last_cmd, 4'h5);
    chk("bus_src", last_src, 1'b0);
    chk("send_gap", 8'(last_gap), 8'd100);
    chk("send_width", 8'(max_run), 8'd1);

    // Bus beats button in the same cycle; wrong address ignored
    BUS_WE = 1; BUS_ADDR = 8'h90; BUS_DATA = 8'h03; BTN_REQ = 1; BTN_CMD = 4'hA;
    step();
    idle_inputs();
    BUS_WE = 1; BUS_ADDR = 8'h91; BUS_DATA = 8'h0F;
    step();
    idle_inputs();
    wait_send(150, k);
    chk("prio_seen", k > 0, 1'b1);
    chk("prio_cmd", last_cmd, 4'h3);
    chk("prio_src", last_src, 1'b0);

    // Button request then silence: three packets, then forced stop
    BTN_REQ = 1; BTN_CMD = 4'h6;
    step();
    idle_inputs();
    base = sends_seen;
    qb = cmd_log.size();
    k = 0;
    while (sends_seen - base < 4 && k < 600) begin
      step();
      k++;
    end
    chk("wd_pkts", 8'(sends_seen - base), 8'd4);
    if (cmd_log.size() >= qb + 4) begin
      chk("wd_p1", cmd_log[qb], 4'h6);
      chk("wd_p2", cmd_log[qb + 1], 4'h6);
      chk("wd_p3", cmd_log[qb + 2], 4'h6);
      chk("wd_p4", cmd_log[qb + 3], 4'h0);
    end
    chk("wd_src", last_src, 1'b1);
    chk("wd_timeout", TIMEOUT, 1'b1);
    BUS_WE = 1; BUS_ADDR = 8'h90; BUS_DATA = 8'h01;
    step();
    idle_inputs();
    chk("wd_clear", TIMEOUT, 1'b0);

    // Transmitter stuck busy for 250 cycles
    chk("pre_overrun", OVERRUN, 1'b0);
    force_busy = 1;
    base = sends_seen;
    run(250);
    force_busy = 0;
    chk("stuck_sends", (sends_seen - base) <= 1, 1'b1);
    chk("stuck_overrun", OVERRUN, 1'b1);

    // Reset mid-packet; a request during reset must be ignored
    BUS_WE = 1; BUS_ADDR = 8'h90; BUS_DATA = 8'h09;
    step();
    idle_inputs();
    wait_send(300, k);
    chk("pre_rst_cmd", COMMAND, 4'h9);
    run(3);
    RST = 1; BTN_REQ = 1; BTN_CMD = 4'h7;
    step();
    RST = 0;
    idle_inputs();
    chk("arst_send", SEND_PACKET, 1'b0);
    chk("arst_command", COMMAND, 4'h0);
    chk("arst_src", SRC, 1'b0);
    chk("arst_timeout", TIMEOUT, 1'b0);
    chk("arst_overrun", OVERRUN, 1'b0);
    wait_send(300, k);
    chk("arst_first_send", 8'(k), 8'd100);
    chk("arst_first_cmd", COMMAND, 4'h0);

    // New request during a packet does not disturb the command in flight
    BUS_WE = 1; BUS_ADDR = 8'h90; BUS_DATA = 8'h0C;
    step();
    idle_inputs();
    wait_send(150, k);
    chk("mid_old", COMMAND, 4'hC);
    run(2);
    BTN_REQ = 1; BTN_CMD = 4'h2;
    step();
    idle_inputs();
    chk("mid_hold", COMMAND, 4'hC);
    wait_send(150, k);
    chk("mid_new", COMMAND, 4'h2);

    // Randomized traffic with occasional resets and stuck transmitter
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      BUS_WE   = (r < 3);
      BUS_ADDR = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h90;
      BUS_DATA = 8'($urandom);
      BTN_REQ  = ($urandom_range(0, 39) == 0);
      BTN_CMD  = 4'($urandom);
      RST      = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 499) == 0) force_busy = !force_busy;
      step();
    end
    RST = 0;
    force_busy = 0;
    idle_inputs();
    run(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
